// File: rtl/uart_ext.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ext
//  Description : Parametrised full-duplex UART with valid/ready TX handshake,
//                majority-voted RX sampling and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  tx,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_frame_err,
    output logic                  rx_parity_err,
    output logic                  rx_overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = 5;
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] C_SMP_A     = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] C_SMP_B     = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] C_SMP_C     = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] C_DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] C_STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = 1'b1;
        tx_bit_end = (tx_cnt_q == C_CNT_LAST);

        case (tx_state_q)
            S_IDLE:  tx_ready = 1'b1;
            S_STOP:  tx_ready = tx_bit_end && (tx_bit_q == C_STOP_LAST);
            default: tx_ready = 1'b0;
        endcase

        if (tx_state_q != S_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end

        // Loading in the last stop cycle gives gap-free back-to-back frames
        if (tx_valid && tx_ready) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
        end else if (tx_bit_end) begin
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                end
                S_DATA: begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == C_DATA_LAST) begin
                        tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    tx_state_d = S_STOP;
                    tx_bit_d   = '0;
                end
                S_STOP: begin
                    if (tx_bit_q == C_STOP_LAST) begin
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
                default: tx_state_d = S_IDLE;
            endcase
        end

        // Line level follows the next state so tx is a clean flop output
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  sync1_q, sync2_q;
    logic                  smp_a_q, smp_b_q;
    state_t                rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_parbit_q, rx_parbit_d;
    logic                  rx_maj, rx_mid, rx_end, rx_complete;
    logic                  rx_par_calc, rx_par_err;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q, rx_frame_err_q, rx_parity_err_q, rx_overrun_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_parbit_d = rx_parbit_q;
        rx_complete = 1'b0;
        rx_maj      = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);
        rx_mid      = (rx_cnt_q == C_SMP_C);
        rx_end      = (rx_cnt_q == C_CNT_LAST);
        rx_par_calc = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
        rx_par_err  = (PARITY != 0) && (rx_parbit_q != rx_par_calc);

        if (rx_state_q != S_IDLE) begin
            rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
        end

        case (rx_state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_mid && rx_maj) begin
                    rx_state_d = S_IDLE;
                    rx_cnt_d   = '0;
                end else if (rx_end) begin
                    rx_state_d = S_DATA;
                    rx_bit_d   = '0;
                end
            end
            S_DATA: begin
                if (rx_mid) begin
                    rx_shift_d                 = rx_shift_q >> 1;
                    rx_shift_d[DATA_WIDTH-1]   = rx_maj;
                end
                if (rx_end) begin
                    if (rx_bit_q == C_DATA_LAST) begin
                        rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        rx_bit_d   = '0;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_mid) begin
                    rx_parbit_d = rx_maj;
                end
                if (rx_end) begin
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_mid) begin
                    rx_complete = 1'b1;
                    rx_state_d  = S_IDLE;
                    rx_cnt_d    = '0;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            smp_a_q     <= 1'b1;
            smp_b_q     <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_parbit_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            if (rx_cnt_q == C_SMP_A) smp_a_q <= sync2_q;
            if (rx_cnt_q == C_SMP_B) smp_b_q <= sync2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_parbit_q <= rx_parbit_d;
        end
    end

    // An unacknowledged word is never overwritten; the new frame only marks overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end else if (rx_complete) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_q       <= rx_shift_q;
                rx_valid_q      <= 1'b1;
                rx_frame_err_q  <= ~rx_maj;
                rx_parity_err_q <= rx_par_err;
                if (rx_ack) rx_overrun_q <= 1'b0;
            end else begin
                rx_overrun_q <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_q      <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_overrun    = rx_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_ext
//  Description : Directed self-checking bench for uart_ext (8N1 and 8E2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    int         tests;
    int         fails;

    // Instance A: default 8N1, rx either looped from tx or driven by the bench
    logic       loop_a;
    logic       rx_drv;
    logic       rx_a;
    logic       tx_a, tx_ready_a, tx_valid_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       rx_valid_a, rx_ack_a, fe_a, pe_a, ov_a;

    assign rx_a = loop_a ? tx_a : rx_drv;

    uart_ext u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx_a),
        .tx            (tx_a),
        .tx_data       (tx_data_a),
        .tx_valid      (tx_valid_a),
        .tx_ready      (tx_ready_a),
        .rx_data       (rx_data_a),
        .rx_valid      (rx_valid_a),
        .rx_ack        (rx_ack_a),
        .rx_frame_err  (fe_a),
        .rx_parity_err (pe_a),
        .rx_overrun    (ov_a)
    );

    // Instance B: even parity, two stop bits, tx looped to rx
    logic       tx_b, tx_ready_b, tx_valid_b;
    logic [7:0] tx_data_b, rx_data_b;
    logic       rx_valid_b, fe_b, pe_b, ov_b;
    logic       rx_ack_b;

    uart_ext #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .PARITY     (2),
        .STOP_BITS  (2)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .rx            (tx_b),
        .tx            (tx_b),
        .tx_data       (tx_data_b),
        .tx_valid      (tx_valid_b),
        .tx_ready      (tx_ready_b),
        .rx_data       (rx_data_b),
        .rx_valid      (rx_valid_b),
        .rx_ack        (rx_ack_b),
        .rx_frame_err  (fe_b),
        .rx_parity_err (pe_b),
        .rx_overrun    (ov_b)
    );

    // Serial frame onto rx_drv, 16 cycles per bit; optional single-cycle glitches
    task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit, input logic glitch);
        logic [9:0] f;
        logic       g;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < 16; p++) begin
                @(negedge clk);
                g = glitch && ((i == 3 && p == 9) || (i == 6 && p == 10) || (i == 7 && p == 8));
                rx_drv = f[i] ^ g;
            end
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_ack_a();
        @(negedge clk);
        rx_ack_a = 1'b1;
        @(negedge clk);
        rx_ack_a = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
        tests++; if (tx_ready_a !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready_a); end
        tests++; if (rx_data_a !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b0000) begin fails++; $display("FAIL reset_rx_flags: got %b expected 0000", {rx_valid_a, fe_a, pe_a, ov_a}); end
        tests++; if (tx_b !== 1'b1) begin fails++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_loopback();
        logic [9:0] exp_frame;
        logic       exp_tx, exp_rdy;
        exp_frame = 10'b1_1010_0101_0;   // stop, A5 MSB..LSB, start
        loop_a = 1'b1;
        @(negedge clk);
        tx_data_a  = 8'hA5;
        tx_valid_a = 1'b1;
        tests++; if (tx_ready_a !== 1'b1) begin fails++; $display("FAIL tx_ready_before: got %b expected 1", tx_ready_a); end
        for (int n = 1; n <= 165; n++) begin
            @(negedge clk);
            if (n == 1) tx_valid_a = 1'b0;
            if (n == 5) tx_data_a = 8'h00;
            exp_tx  = (n <= 160) ? exp_frame[(n - 1) / 16] : 1'b1;
            exp_rdy = (n >= 160);
            tests++; if (tx_a !== exp_tx) begin fails++; $display("FAIL tx_frame cycle %0d: got %b expected %b", n, tx_a, exp_tx); end
            tests++; if (tx_ready_a !== exp_rdy) begin fails++; $display("FAIL tx_ready cycle %0d: got %b expected %b", n, tx_ready_a, exp_rdy); end
        end
        for (int k = 0; k < 100 && !rx_valid_a; k++) @(negedge clk);
        tests++; if (rx_valid_a !== 1'b1) begin fails++; $display("FAIL loop_rx_valid: got %b expected 1", rx_valid_a); end
        tests++; if (rx_data_a !== 8'hA5) begin fails++; $display("FAIL loop_rx_data: got %h expected a5", rx_data_a); end
        tests++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin fails++; $display("FAIL loop_rx_flags: got %b expected 000", {fe_a, pe_a, ov_a}); end
        pulse_ack_a();
        tests++; if (rx_valid_a !== 1'b0) begin fails++; $display("FAIL loop_ack_valid: got %b expected 0", rx_valid_a); end
        loop_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_frame;
        logic        exp_tx, exp_rdy;
        exp_frame = 12'b11_1_0000_0111_0;   // 2 stops, even parity 1, 07, start
        @(negedge clk);
        tx_data_b  = 8'h07;
        tx_valid_b = 1'b1;
        for (int n = 1; n <= 208; n++) begin
            @(negedge clk);
            if (n == 193) tx_valid_b = 1'b0;
            exp_tx  = (n <= 192) ? exp_frame[(n - 1) / 16] : 1'b0;
            exp_rdy = (n == 192);
            tests++; if (tx_b !== exp_tx) begin fails++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", n, tx_b, exp_tx); end
            tests++; if (tx_ready_b !== exp_rdy) begin fails++; $display("FAIL b2b_tx_ready cycle %0d: got %b expected %b", n, tx_ready_b, exp_rdy); end
        end
        repeat (190) @(negedge clk);
        tests++; if (rx_data_b !== 8'h07) begin fails++; $display("FAIL b2b_rx_data: got %h expected 07", rx_data_b); end
        tests++; if ({rx_valid_b, fe_b, pe_b, ov_b} !== 4'b1001) begin fails++; $display("FAIL b2b_rx_flags: got %b expected 1001", {rx_valid_b, fe_b, pe_b, ov_b}); end
    endtask

    task automatic test_frame_error();
        drive_rx_frame(8'h3C, 1'b0, 1'b0);
        tests++; if (rx_data_a !== 8'h3C) begin fails++; $display("FAIL ferr_rx_data: got %h expected 3c", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b1100) begin fails++; $display("FAIL ferr_flags: got %b expected 1100", {rx_valid_a, fe_a, pe_a, ov_a}); end
        pulse_ack_a();
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b0000) begin fails++; $display("FAIL ferr_ack_flags: got %b expected 0000", {rx_valid_a, fe_a, pe_a, ov_a}); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overrun();
        drive_rx_frame(8'h11, 1'b1, 1'b0);
        tests++; if ({rx_valid_a, ov_a} !== 2'b10) begin fails++; $display("FAIL ovr_first: got %b expected 10", {rx_valid_a, ov_a}); end
        drive_rx_frame(8'h22, 1'b1, 1'b0);
        tests++; if (rx_data_a !== 8'h11) begin fails++; $display("FAIL ovr_rx_data: got %h expected 11", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b1001) begin fails++; $display("FAIL ovr_flags: got %b expected 1001", {rx_valid_a, fe_a, pe_a, ov_a}); end
        // Ack lands on the cycle the stop bit is decided
        fork
            drive_rx_frame(8'h33, 1'b1, 1'b0);
            begin
                repeat (157) @(negedge clk);
                rx_ack_a = 1'b1;
                @(negedge clk);
                rx_ack_a = 1'b0;
            end
        join
        tests++; if (rx_data_a !== 8'h33) begin fails++; $display("FAIL ovr_ack_data: got %h expected 33", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b1000) begin fails++; $display("FAIL ovr_ack_flags: got %b expected 1000", {rx_valid_a, fe_a, pe_a, ov_a}); end
        pulse_ack_a();
        tests++; if ({rx_valid_a, ov_a} !== 2'b00) begin fails++; $display("FAIL ovr_final_ack: got %b expected 00", {rx_valid_a, ov_a}); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b0000) begin fails++; $display("FAIL false_start: got %b expected 0000", {rx_valid_a, fe_a, pe_a, ov_a}); end
        drive_rx_frame(8'h5A, 1'b1, 1'b1);
        tests++; if (rx_data_a !== 8'h5A) begin fails++; $display("FAIL glitch_rx_data: got %h expected 5a", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b1000) begin fails++; $display("FAIL glitch_flags: got %b expected 1000", {rx_valid_a, fe_a, pe_a, ov_a}); end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        tx_data_a  = 8'h96;
        tx_valid_a = 1'b1;
        rx_drv     = 1'b0;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (50) @(negedge clk);
        tests++; if (tx_ready_a !== 1'b0) begin fails++; $display("FAIL midframe_busy: got %b expected 0", tx_ready_a); end
        reset = 1'b1;
        #1;
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL midreset_tx: got %b expected 1", tx_a); end
        tests++; if (tx_ready_a !== 1'b1) begin fails++; $display("FAIL midreset_tx_ready: got %b expected 1", tx_ready_a); end
        tests++; if ({rx_valid_a, rx_data_a} !== 9'h000) begin fails++; $display("FAIL midreset_rx: got %h expected 000", {rx_valid_a, rx_data_a}); end
        rx_drv = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({tx_a, tx_ready_a, rx_valid_a} !== 3'b110) begin fails++; $display("FAIL postreset_idle: got %b expected 110", {tx_a, tx_ready_a, rx_valid_a}); end
        drive_rx_frame(8'hC3, 1'b1, 1'b0);
        tests++; if (rx_data_a !== 8'hC3) begin fails++; $display("FAIL postreset_rx_data: got %h expected c3", rx_data_a); end
        tests++; if ({rx_valid_a, fe_a, pe_a, ov_a} !== 4'b1000) begin fails++; $display("FAIL postreset_flags: got %b expected 1000", {rx_valid_a, fe_a, pe_a, ov_a}); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        loop_a     = 1'b0;
        rx_drv     = 1'b1;
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b0;
        rx_ack_a   = 1'b0;
        tx_data_b  = 8'h00;
        tx_valid_b = 1'b0;
        rx_ack_b   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_tx_loopback();
        test_back_to_back();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ext.md
Name: uart_ext

Overview:
Parametrised full-duplex UART, successor to the fixed 10x-oversampled 8N1 UART block.
- Configurable data width, oversampling ratio, parity mode and stop-bit count.
- Valid/ready transmit handshake.
- RX input synchroniser with 3-sample majority vote per bit.
- Sticky framing, parity and overrun error flags.
- Sits between a board-level serial pin pair and a host-side controller or FIFO.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..16), sent and received LSB first
OVERSAMPLE, 16, clk cycles per bit (even, >=4)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks only the first

Ports:
clk  input  1  clock at OVERSAMPLE x baud rate
reset  input  1  asynchronous, active-high reset
rx  input  1  serial input, asynchronous to clk
tx  output  1  serial output, idle high
tx_data  input  DATA_WIDTH  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  transmitter can accept a word
rx_data  output  DATA_WIDTH  last received word
rx_valid  output  1  rx_data holds an unacknowledged word
rx_ack  input  1  clears rx_valid and all error flags
rx_frame_err  output  1  sticky: stop bit sampled 0
rx_parity_err  output  1  sticky: parity mismatch
rx_overrun  output  1  sticky: a frame completed while rx_valid was set

Behaviour:
- Reset (async, active-high): tx=1, tx_ready=1, rx_data=0, rx_valid=0, all error flags 0, both synchroniser flops=1, both FSMs in IDLE. Reset mid-frame aborts the frame immediately, with no partial output.
- Bit timing: each FSM has its own cycle counter c running 0..OVERSAMPLE-1, plus a bit index.
- TX FSM, states IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP:
  - Handshake occurs on the cycle where tx_valid && tx_ready. On that edge tx_data is latched, tx_ready goes 0 and the FSM enters START. tx=0 from the next cycle.
  - Each bit is held on tx for exactly OVERSAMPLE cycles. Parity covers data bits only.
  - STOP lasts STOP_BITS*OVERSAMPLE cycles with tx=1. tx_ready=1 during the final STOP cycle.
  - If tx_valid is held high, frames run back-to-back with period OVERSAMPLE*(1+DATA_WIDTH+(PARITY!=0)+STOP_BITS) cycles exactly.
  - tx_data changes while tx_ready=0 are ignored.
- RX path:
  - rx passes through a 2-flop synchroniser; rxs denotes its output.
  - IDLE: on rxs=0, go to START with c=0.
  - Majority vote: with H=OVERSAMPLE/2, rxs is sampled at c=H-1, H and H+1. The majority value is taken at c=H+1.
  - START: if the majority is 1, this is a false start; return to IDLE and emit no flags.
  - DATA: shift in DATA_WIDTH majority bits, LSB first. Then PARITY if enabled, then STOP, each bit one OVERSAMPLE period apart.
  - STOP is decided at its c=H+1. On the next cycle the FSM returns to IDLE and the completion update happens (rx_valid or overrun asserts). A new start edge is accepted on that same cycle.
- RX completion, when rx_valid=0 or rx_ack=1 in the completion cycle:
  - rx_data <= word and rx_valid <= 1.
  - rx_frame_err <= (stop==0) and rx_parity_err <= mismatch. These reflect the new frame.
  - rx_overrun <= 0 if rx_ack, else unchanged.
- RX completion, when rx_valid=1 and rx_ack=0: rx_data is kept, rx_overrun <= 1, and the new frame's errors are discarded.
- rx_ack with no completion in the same cycle: rx_valid and all three flags go to 0 next cycle.
- A frame with a framing error or parity error still delivers its data.

Test Plan:
1. Defaults: send tx_data=8'hA5 -> tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. tx_ready returns 1 exactly 160 cycles after the handshake. Loop tx to rx: rx_data=8'hA5, rx_valid=1, all flags 0.
2. PARITY=2, STOP_BITS=2: send 8'h07 -> parity bit 1, then 32 high cycles. tx_valid held for two frames -> second start bit begins exactly 192 cycles after the first.
3. Drive rx with a 0x3C frame whose stop bit is forced 0 -> rx_data=8'h3C, rx_frame_err=1. rx_ack -> all flags 0.
4. Receive 8'h11 then 8'h22 without ack -> rx_data=8'h11, rx_overrun=1. Ack coincident with a third frame 8'h33 -> rx_data=8'h33, rx_valid=1, rx_overrun=0.
5. Glitches: rx low for 3 cycles (false start) -> no rx_valid. A one-cycle inverted glitch at mid-bit of data bit 2 -> rx_data unaffected (majority vote).
6. Assert reset mid-frame in both directions -> tx=1 and tx_ready=1 immediately. After release, a fresh 8'hC3 frame is received correctly.
